// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter: round-robin arbiter that shares a single WIDTH-bit
// add/sub datapath between NREQ valid/ready requesters and returns one
// registered, ID-tagged result per accepted request.
// Optional build macro ADDSUB_SHARE_ARBITER_COUT_EN adds a registered carry-out
// port, RSP_COUT. For a subtract, RSP_COUT=1 means no borrow occurred.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | no result held, RSP_VALID=0
// S_FULL  | result held in output register, RSP_VALID=1
module addsub_share_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 2,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ-1:0]       REQ_OP,
  input  logic [NREQ*WIDTH-1:0] REQ_I0,
  input  logic [NREQ*WIDTH-1:0] REQ_I1,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [IDW-1:0]        RSP_ID,
  output logic [WIDTH-1:0]      RSP_O
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
  ,
  output logic                  RSP_COUT
`endif
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     cand;
  logic             gnt_found;
  logic             can_accept;
  logic             handshake;
  logic [WIDTH-1:0] i0_arr [NREQ];
  logic [WIDTH-1:0] i1_arr [NREQ];
  logic             op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b_eff;
  logic [WIDTH-1:0] res;
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
  logic             cout_q, cout_d, cout_sum;
`endif

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      i0_arr[k] = REQ_I0[k*WIDTH +: WIDTH];
      i1_arr[k] = REQ_I1[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin scan starting at ptr; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && REQ_VALID[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  // Shared adder: subtract is I0 + ~I1 + 1, so the op bit doubles as carry-in.
  always_comb begin
    op_sel   = REQ_OP[gnt_idx];
    op_a     = i0_arr[gnt_idx];
    op_b_eff = op_sel ? ~i1_arr[gnt_idx] : i1_arr[gnt_idx];
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
    {cout_sum, res} = {1'b0, op_a} + {1'b0, op_b_eff} + (WIDTH+1)'(op_sel);
`else
    res = op_a + op_b_eff + WIDTH'(op_sel);
`endif
  end

  // Grant, output-register FSM and next-value selection.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    o_d        = o_q;
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
    cout_d     = cout_q;
`endif
    REQ_READY  = '0;
    can_accept = (state_q == S_EMPTY) | RSP_READY;
    handshake  = gnt_found & can_accept & !RESET;
    if (handshake) REQ_READY[gnt_idx] = 1'b1;

    case (state_q)
      S_EMPTY: if (handshake) state_d = S_FULL;
      S_FULL:  if (!handshake && RSP_READY) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    if (handshake) begin
      o_d   = res;
      id_d  = gnt_idx;
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
      cout_d = cout_sum;
`endif
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      o_q     <= '0;
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      o_q     <= o_d;
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign RSP_VALID = (state_q == S_FULL);
  assign RSP_ID    = id_q;
  assign RSP_O     = o_q;
`ifdef ADDSUB_SHARE_ARBITER_COUT_EN
  assign RSP_COUT  = cout_q;
`endif

endmodule
